csa42_accum: RTL

Parametrised, pipelined carry-save accumulator built from rows of 4:2 compressors. Each accepted beat supplies four unsigned operands. The block folds them into a redundant sum/carry state register with no carry propagation on the accumulate path. On the last beat of a packet it performs one carry-propagate add and presents the total on a valid/ready output. It is the next-generation multi-operand adder for the datapath, generalising the single-bit 4:2 compressor to vectors, multiple beats and a handshake.

---
 rtl/csa42_accum_if.sv | 28 ++
 rtl/csa42_accum.sv | 108 ++++++++++
 2 files changed

// File: rtl/csa42_accum_if.sv
// Beat-in / result-out handshake bundle for the carry-save accumulator.
interface csa42_accum_if #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_c;
    logic [WIDTH-1:0] in_d;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_last, in_a, in_b, in_c, in_d, out_ready,
        input  in_ready, out_valid, out_sum, out_count
    );

    modport slave (
        input  in_valid, in_last, in_a, in_b, in_c, in_d, out_ready,
        output in_ready, out_valid, out_sum, out_count
    );
endinterface

// File: rtl/csa42_accum.sv
// Multi-beat carry-save accumulator built from two rows of 4:2 compressors,
// resolved with a single carry-propagate add at the end of each packet.
module csa42_accum #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    csa42_accum_if.slave     bus
);

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        OUT     = 2'd2
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc_s;
    logic [ACC_W-1:0] acc_c;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] sum_q;
    logic [CNT_W-1:0] cnt_q;

    logic [ACC_W-1:0] ea, eb, ec, ed;
    logic [ACC_W-1:0] sa, ca;
    logic [ACC_W-1:0] ns, nc;

    // Returns {C, S}; MSB carries out of both adders are dropped (mod 2^ACC_W).
    function automatic logic [2*ACC_W-1:0] compress(
        input logic [ACC_W-1:0] x0,
        input logic [ACC_W-1:0] x1,
        input logic [ACC_W-1:0] x2,
        input logic [ACC_W-1:0] x3
    );
        logic [ACC_W-1:0] s;
        logic [ACC_W-1:0] c;
        logic             s1;
        logic             co;
        logic             ci;
        s  = '0;
        c  = '0;
        ci = 1'b0;
        for (int i = 0; i < ACC_W; i++) begin
            s1   = x0[i] ^ x1[i] ^ x2[i];
            co   = (x0[i] & x1[i]) | (x0[i] & x2[i]) | (x1[i] & x2[i]);
            s[i] = s1 ^ x3[i] ^ ci;
            if (i < ACC_W - 1)
                c[i+1] = (s1 & x3[i]) | (s1 & ci) | (x3[i] & ci);
            ci = co;
        end
        return {c, s};
    endfunction

    always_comb begin
        ea = {{(ACC_W-WIDTH){1'b0}}, bus.in_a};
        eb = {{(ACC_W-WIDTH){1'b0}}, bus.in_b};
        ec = {{(ACC_W-WIDTH){1'b0}}, bus.in_c};
        ed = {{(ACC_W-WIDTH){1'b0}}, bus.in_d};
        {ca, sa} = compress(ea, eb, ec, ed);
        {nc, ns} = compress(sa, ca, acc_s, acc_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
            acc_s <= '0;
            acc_c <= '0;
            cnt   <= '0;
            sum_q <= '0;
            cnt_q <= '0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (bus.in_valid) begin
                        acc_s <= ns;
                        acc_c <= nc;
                        if (cnt != '1)
                            cnt <= cnt + 1'b1;
                        if (bus.in_last)
                            state <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    sum_q <= acc_s + acc_c;
                    cnt_q <= cnt;
                    state <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        acc_s <= '0;
                        acc_c <= '0;
                        cnt   <= '0;
                        state <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == OUT);
    assign bus.out_sum   = sum_q;
    assign bus.out_count = cnt_q;

endmodule
